ts_ip_cfg_sched: RTL

//  Host-side configuration scheduler for the TS IP/port reject filter.
//  - Queues filter-table entry writes from the host.
//  - Serialises each entry into the 8-byte ip_port_con byte stream consumed by the filter.
//  - Starts a burst only in an idle gap of the TS input stream, so table updates never

---
 rtl/ts_ip_cfg_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ts_ip_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : ts_ip_cfg_sched
// Purpose  : Queues host filter-table writes and serialises each entry as an
//            8-byte ip_port_con burst, started only in an idle TS input gap.
// Revision : 1.0
// ============================================================================
module ts_ip_cfg_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_MIN    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_wr,
    input  logic [7:0]                  cfg_idx,
    input  logic [31:0]                 cfg_ip,
    input  logic [15:0]                 cfg_port,
    input  logic [7:0]                  cfg_flag,
    output logic                        cfg_ready,
    output logic                        cfg_ovf,
    input  logic                        cfg_ovf_clr,
    output logic                        cfg_done,
    output logic [$clog2(FIFO_DEPTH):0] cfg_pending,
    input  logic                        ts_din_en,
    output logic [7:0]                  ip_port_con_dout,
    output logic                        ip_port_con_dout_en
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          dout_en_q, dout_en_d;
    logic [7:0]    dout_q, dout_d;
    logic [63:0]   shift_q, shift_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    state_t        state_q, state_d;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_gap_ok;
    logic [63:0]   w_head;

    // Gap monitor: counts idle TS cycles, saturating at GAP_MIN.
    generate
        if (GAP_MIN == 0) begin : g_gap_off
            assign w_gap_ok = 1'b1;
        end else begin : g_gap_on
            localparam int            GW        = $clog2(GAP_MIN + 1);
            localparam logic [GW-1:0] C_GAP_MIN = GW'(GAP_MIN);
            logic [GW-1:0] gap_q, gap_d;

            always_comb begin
                gap_d = gap_q;
                if (ts_din_en) begin
                    gap_d = '0;
                end else if (gap_q != C_GAP_MIN) begin
                    gap_d = gap_q + GW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_d;
                end
            end

            assign w_gap_ok = (gap_q == C_GAP_MIN);
        end
    endgenerate

    assign w_empty = (count_q == '0);
    assign w_head  = mem_q[rd_ptr_q];
    assign w_push  = cfg_wr && ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        dout_d     = 8'h00;
        dout_en_d  = 1'b0;
        done_d     = 1'b0;
        w_pop      = 1'b0;

        // A new entry is taken either from idle after a gap, or chained
        // straight after byte 7 while the TS input is quiet.
        if (state_q == ST_IDLE) begin
            w_pop = !w_empty && w_gap_ok;
        end else if (byte_cnt_q == 3'd7) begin
            w_pop = !w_empty && !ts_din_en;
        end

        if (w_pop) begin
            state_d    = ST_SEND;
            dout_d     = w_head[63:56];
            shift_d    = {w_head[55:0], 8'h00};
            byte_cnt_d = 3'd0;
            dout_en_d  = 1'b1;
        end else if (state_q == ST_SEND && byte_cnt_q != 3'd7) begin
            dout_d     = shift_q[63:56];
            shift_d    = {shift_q[55:0], 8'h00};
            byte_cnt_d = byte_cnt_q + 3'd1;
            dout_en_d  = 1'b1;
            done_d     = (byte_cnt_q == 3'd6);
        end else begin
            state_d    = ST_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        ready_d = (count_d != C_DEPTH);

        // A dropped write wins over a clear in the same cycle.
        ovf_d = ovf_q;
        if (cfg_wr && !ready_q) begin
            ovf_d = 1'b1;
        end else if (cfg_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cfg_idx, cfg_ip, cfg_port, cfg_flag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            dout_en_q  <= 1'b0;
            dout_q     <= 8'h00;
            shift_q    <= '0;
            byte_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            dout_en_q  <= dout_en_d;
            dout_q     <= dout_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign cfg_ready           = ready_q;
    assign cfg_ovf             = ovf_q;
    assign cfg_done            = done_q;
    assign cfg_pending         = count_q;
    assign ip_port_con_dout    = dout_q;
    assign ip_port_con_dout_en = dout_en_q;

endmodule
`default_nettype wire
